// File: rtl/reconfig_consolidate_ctrl_pkg.sv
// Shared core-configuration package for the reconfiguration controller:
// FSM state encoding and counter-sizing helper.
package reconfig_consolidate_ctrl_pkg;

    typedef enum logic [2:0] {
        RCC_IDLE      = 3'd0,
        RCC_DRAIN     = 3'd1,
        RCC_SETTLE    = 3'd2,
        RCC_START     = 3'd3,
        RCC_WAIT_DONE = 3'd4,
        RCC_APPLY     = 3'd5
    } rcc_state_e;

    // Width of a down/up counter that must hold values 0..n-1, at least 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : reconfig_consolidate_ctrl_pkg

// File: rtl/reconfig_consolidate_ctrl_watchdog.sv
// Consolidation watchdog: counts enabled cycles after a clear and flags
// expiry once TIMEOUT_CYCLES-1 is reached. The count saturates there.
module consolidate_watchdog
    import reconfig_consolidate_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int              WD_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_count;

    // Watchdog count: clear on start, advance while enabled, hold at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != WD_LAST)) begin
            r_count <= r_count + WD_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == WD_LAST);

endmodule : consolidate_watchdog

// File: rtl/reconfig_consolidate_ctrl.sv
// Reconfiguration controller: stalls the front end, waits for the pipeline
// to drain and stay drained, kicks the register consolidation engine, and
// applies the new configuration once the engine reports completion.
module reconfig_consolidate_ctrl
    import reconfig_consolidate_ctrl_pkg::*;
#(
    parameter int               CFG_W          = 8,
    parameter int               SETTLE_CYCLES  = 4,
    parameter int               TIMEOUT_CYCLES = 1024,
    parameter logic [CFG_W-1:0] RESET_CFG      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reconfigReq_i,
    input  logic [CFG_W-1:0] newCfg_i,
    input  logic             robEmpty_i,
    input  logic             lsqEmpty_i,
    input  logic             issueQEmpty_i,
    input  logic             doneConsolidate_i,
    output logic             startConsolidate_o,
    output logic             stallFetch_o,
    output logic [CFG_W-1:0] activeCfg_o,
    output logic             reconfigAck_o,
    output logic             timeoutErr_o
);

    localparam int            SW          = cnt_width(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    rcc_state_e       r_state;
    logic [SW-1:0]    r_settle_cnt;
    logic [CFG_W-1:0] r_pending_cfg;
    logic [CFG_W-1:0] r_active_cfg;
    logic             r_start;
    logic             r_stall;
    logic             r_ack;
    logic             r_timeout_err;

    logic w_all_empty;
    logic w_wd_clear;
    logic w_wd_enable;
    logic w_wd_expired;

    assign w_all_empty = robEmpty_i & lsqEmpty_i & issueQEmpty_i;
    // The watchdog restarts in START and only runs while still waiting on
    // the engine, so a done arriving on the limit cycle still wins.
    assign w_wd_clear  = (r_state == RCC_START);
    assign w_wd_enable = (r_state == RCC_WAIT_DONE) && !doneConsolidate_i;

    consolidate_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

    // Controller FSM; pulse/stall outputs are registered together with the
    // state they belong to, so they are exact functions of the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RCC_IDLE;
            r_settle_cnt  <= '0;
            r_pending_cfg <= '0;
            r_active_cfg  <= RESET_CFG;
            r_start       <= 1'b0;
            r_stall       <= 1'b0;
            r_ack         <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_ack   <= 1'b0;
            case (r_state)
                RCC_IDLE: begin
                    // A tripped watchdog locks out further reconfiguration.
                    if (reconfigReq_i && !r_timeout_err) begin
                        r_pending_cfg <= newCfg_i;
                        r_state       <= RCC_DRAIN;
                        r_stall       <= 1'b1;
                    end else begin
                        r_state <= RCC_IDLE;
                        r_stall <= 1'b0;
                    end
                end
                RCC_DRAIN: begin
                    if (w_all_empty) begin
                        r_settle_cnt <= SETTLE_LAST;
                        r_state      <= RCC_SETTLE;
                    end else begin
                        r_state <= RCC_DRAIN;
                    end
                end
                RCC_SETTLE: begin
                    if (!w_all_empty) begin
                        r_state <= RCC_DRAIN;
                    end else if (r_settle_cnt == '0) begin
                        r_state <= RCC_START;
                        r_start <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - SW'(1);
                    end
                end
                RCC_START: begin
                    r_state <= RCC_WAIT_DONE;
                end
                RCC_WAIT_DONE: begin
                    if (doneConsolidate_i) begin
                        r_state <= RCC_APPLY;
                        r_ack   <= 1'b1;
                    end else if (w_wd_expired) begin
                        r_state       <= RCC_IDLE;
                        r_stall       <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_state <= RCC_WAIT_DONE;
                    end
                end
                RCC_APPLY: begin
                    r_active_cfg <= r_pending_cfg;
                    r_state      <= RCC_IDLE;
                    r_stall      <= 1'b0;
                end
                default: begin
                    r_state <= RCC_IDLE;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign startConsolidate_o = r_start;
    assign stallFetch_o       = r_stall;
    assign activeCfg_o        = r_active_cfg;
    assign reconfigAck_o      = r_ack;
    assign timeoutErr_o       = r_timeout_err;

endmodule : reconfig_consolidate_ctrl

// File: tb/tb_reconfig_consolidate_ctrl.sv
// Directed self-checking bench for reconfig_consolidate_ctrl
// (SETTLE_CYCLES=4, TIMEOUT_CYCLES=16, CFG_W=8, RESET_CFG=0x5A).
module tb_reconfig_consolidate_ctrl;

    localparam int         CFG_W = 8;
    localparam logic [7:0] RCFG  = 8'h5A;

    logic             clk;
    logic             reset;
    logic             reconfigReq_i;
    logic [CFG_W-1:0] newCfg_i;
    logic             robEmpty_i;
    logic             lsqEmpty_i;
    logic             issueQEmpty_i;
    logic             doneConsolidate_i;
    logic             startConsolidate_o;
    logic             stallFetch_o;
    logic [CFG_W-1:0] activeCfg_o;
    logic             reconfigAck_o;
    logic             timeoutErr_o;

    int total;
    int bad;

    reconfig_consolidate_ctrl #(
        .CFG_W          (CFG_W),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (16),
        .RESET_CFG      (RCFG)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .reconfigReq_i      (reconfigReq_i),
        .newCfg_i           (newCfg_i),
        .robEmpty_i         (robEmpty_i),
        .lsqEmpty_i         (lsqEmpty_i),
        .issueQEmpty_i      (issueQEmpty_i),
        .doneConsolidate_i  (doneConsolidate_i),
        .startConsolidate_o (startConsolidate_o),
        .stallFetch_o       (stallFetch_o),
        .activeCfg_o        (activeCfg_o),
        .reconfigAck_o      (reconfigAck_o),
        .timeoutErr_o       (timeoutErr_o)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_empty(input logic v);
        robEmpty_i    = v;
        lsqEmpty_i    = v;
        issueQEmpty_i = v;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        reconfigReq_i     = 1'b0;
        newCfg_i          = 8'h00;
        doneConsolidate_i = 1'b0;
        set_empty(1'b0);
        tick();
        tick();

        // Reset state
        chk1("rst_stall", stallFetch_o, 1'b0);
        chk1("rst_start", startConsolidate_o, 1'b0);
        chk1("rst_ack", reconfigAck_o, 1'b0);
        chk1("rst_tmo", timeoutErr_o, 1'b0);
        chk8("rst_cfg", activeCfg_o, RCFG);
        reset = 1'b0;
        tick();
        chk1("idle_stall", stallFetch_o, 1'b0);

        // Basic flow: 0x3C, pipeline already empty, done 3 cycles after start
        set_empty(1'b1);
        reconfigReq_i = 1'b1;
        newCfg_i      = 8'h3C;
        tick();
        chk1("A_stall", stallFetch_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("A_nostart", startConsolidate_o, 1'b0);
        end
        tick();
        chk1("A_start", startConsolidate_o, 1'b1);
        tick();
        chk1("A_start_once", startConsolidate_o, 1'b0);
        tick();
        chk1("A_noack", reconfigAck_o, 1'b0);
        tick();
        doneConsolidate_i = 1'b1;
        tick();
        chk1("A_ack", reconfigAck_o, 1'b1);
        chk8("A_cfg_hold", activeCfg_o, RCFG);
        chk1("A_stall_apply", stallFetch_o, 1'b1);
        doneConsolidate_i = 1'b0;
        reconfigReq_i     = 1'b0;
        tick();
        chk1("A_ack_once", reconfigAck_o, 1'b0);
        chk1("A_unstall", stallFetch_o, 1'b0);
        chk8("A_cfg", activeCfg_o, 8'h3C);

        // Settle interrupted by lsqEmpty_i dropping in the 2nd SETTLE cycle
        reconfigReq_i = 1'b1;
        newCfg_i      = 8'h77;
        tick();                        // DRAIN
        reconfigReq_i = 1'b0;
        tick();                        // SETTLE cycle 1
        chk1("B_nostart1", startConsolidate_o, 1'b0);
        tick();                        // SETTLE cycle 2
        lsqEmpty_i = 1'b0;
        tick();                        // back to DRAIN
        chk1("B_nostart2", startConsolidate_o, 1'b0);
        lsqEmpty_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("B_nostart3", startConsolidate_o, 1'b0);
        end
        tick();
        chk1("B_start", startConsolidate_o, 1'b1);
        tick();
        doneConsolidate_i = 1'b1;
        tick();
        chk1("B_ack", reconfigAck_o, 1'b1);
        doneConsolidate_i = 1'b0;
        tick();
        chk8("B_cfg", activeCfg_o, 8'h77);

        // Spurious done in DRAIN, newCfg_i changed mid-flow
        set_empty(1'b0);
        reconfigReq_i = 1'b1;
        newCfg_i      = 8'h3C;
        tick();                        // DRAIN
        doneConsolidate_i = 1'b1;
        reconfigReq_i     = 1'b0;
        newCfg_i          = 8'h11;
        tick();
        chk1("D_spur_ack", reconfigAck_o, 1'b0);
        chk1("D_spur_stall", stallFetch_o, 1'b1);
        tick();
        chk1("D_spur_ack2", reconfigAck_o, 1'b0);
        doneConsolidate_i = 1'b0;
        set_empty(1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("D_nostart", startConsolidate_o, 1'b0);
        end
        tick();
        chk1("D_start", startConsolidate_o, 1'b1);
        tick();
        chk1("D_noack", reconfigAck_o, 1'b0);
        doneConsolidate_i = 1'b1;
        tick();
        chk1("D_ack", reconfigAck_o, 1'b1);
        doneConsolidate_i = 1'b0;
        tick();
        chk8("D_cfg", activeCfg_o, 8'h3C);

        // Request held through ack is taken as a new request
        reconfigReq_i = 1'b1;
        newCfg_i      = 8'h42;
        for (int i = 0; i < 6; i++) tick();   // DRAIN, 4x SETTLE, START
        chk1("F_start", startConsolidate_o, 1'b1);
        tick();
        doneConsolidate_i = 1'b1;
        tick();
        chk1("F_ack", reconfigAck_o, 1'b1);
        doneConsolidate_i = 1'b0;
        tick();                        // IDLE with request still high
        chk1("F_idle", stallFetch_o, 1'b0);
        chk8("F_cfg", activeCfg_o, 8'h42);
        newCfg_i = 8'hC3;
        tick();                        // new request accepted
        chk1("F_rereq", stallFetch_o, 1'b1);
        reconfigReq_i = 1'b0;

        // Reset while in WAIT_DONE
        for (int i = 0; i < 6; i++) tick();   // 4x SETTLE, START, WAIT_DONE
        chk1("E_in_wait", stallFetch_o, 1'b1);
        reset = 1'b1;
        #1;
        chk1("E_stall", stallFetch_o, 1'b0);
        chk1("E_start", startConsolidate_o, 1'b0);
        chk1("E_ack", reconfigAck_o, 1'b0);
        chk1("E_tmo", timeoutErr_o, 1'b0);
        chk8("E_cfg", activeCfg_o, RCFG);
        doneConsolidate_i = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk1("E_noack", reconfigAck_o, 1'b0);
        chk1("E_idle", stallFetch_o, 1'b0);
        doneConsolidate_i = 1'b0;

        // Watchdog timeout: no done after start
        reconfigReq_i = 1'b1;
        newCfg_i      = 8'hE7;
        for (int i = 0; i < 6; i++) tick();   // DRAIN, 4x SETTLE, START
        chk1("C_start", startConsolidate_o, 1'b1);
        reconfigReq_i = 1'b0;
        for (int i = 0; i < 16; i++) begin    // 16 WAIT_DONE cycles
            tick();
            chk1("C_no_tmo", timeoutErr_o, 1'b0);
        end
        tick();
        chk1("C_tmo", timeoutErr_o, 1'b1);
        chk1("C_unstall", stallFetch_o, 1'b0);
        chk1("C_noack", reconfigAck_o, 1'b0);
        chk8("C_cfg", activeCfg_o, RCFG);
        reconfigReq_i     = 1'b1;
        newCfg_i          = 8'h99;
        doneConsolidate_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1("C_ignored", stallFetch_o, 1'b0);
        end
        chk1("C_tmo_sticky", timeoutErr_o, 1'b1);
        chk1("C_nostart", startConsolidate_o, 1'b0);
        chk8("C_cfg2", activeCfg_o, RCFG);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reconfig_consolidate_ctrl
